vrf_seq: RTL and testbench

- Per-instruction element sequencer for the vector register file (vrf).
- Accepts one element-wise vector op (vd <- f(vs1, vs2)) with an active length vl, then walks the elements lanes_p at a time.
- Drives the vrf r0/r1 read addresses and a lane-valid strobe to the execution lanes.
- Generates the matching vrf write address and write enables after a fixed execution latency. Lane results drive vrf w_data_i directly.

---
 rtl/vrf_seq.sv | 279 +++++++++++++++++++++++++++
 tb/tb_vrf_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_seq.sv
// vrf_seq: per-instruction element sequencer driving vrf read/write addresses and lane strobes.
// Defining VRF_SEQ_PERF_EN adds the ops_done_o completed-op counter.
module vrf_seq #(
    parameter int els_p         = 32,
    parameter int vlen_p        = 8,
    parameter int lanes_p       = 4,
    parameter int exe_latency_p = 2,
    localparam int vaw   = $clog2(els_p),
    localparam int law   = $clog2(vlen_p),
    localparam int aw    = vaw + law,
    localparam int vlw   = $clog2(vlen_p + 1),
    localparam int beats = vlen_p / lanes_p,
    localparam int bw    = (beats > 1) ? $clog2(beats) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  v_i,
    output logic                  ready_o,
    input  logic [vaw-1:0]        vd_i,
    input  logic [vaw-1:0]        vs1_i,
    input  logic [vaw-1:0]        vs2_i,
    input  logic [vlw-1:0]        vl_i,
    output logic [lanes_p*aw-1:0] r0_addr_o,
    output logic [lanes_p*aw-1:0] r1_addr_o,
    output logic [lanes_p-1:0]    exe_v_o,
    output logic [lanes_p*aw-1:0] w_addr_o,
    output logic [lanes_p-1:0]    w_en_o,
    output logic                  done_o
`ifdef VRF_SEQ_PERF_EN
    ,
    output logic [31:0]           ops_done_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic               v;
        logic               last;
        logic [lanes_p-1:0] mask;
        logic [bw-1:0]      beat;
    } wbeat_t;

    function automatic logic [law-1:0] elem_idx(input logic [bw-1:0] beat, input int l);
        int t;
        t = int'(beat) * lanes_p + l;
        return t[law-1:0];
    endfunction

    function automatic logic [lanes_p-1:0] lane_mask(input logic [bw-1:0] beat,
                                                     input logic [vlw-1:0] vl);
        logic [lanes_p-1:0] m;
        m = {lanes_p{1'b0}};
        for (int l = 0; l < lanes_p; l++) begin
            m[l] = ((int'(beat) * lanes_p + l) < int'(vl));
        end
        return m;
    endfunction

    // Index of the final beat, ceil(vl/lanes)-1; only meaningful for vl > 0.
    function automatic logic [bw-1:0] last_beat(input logic [vlw-1:0] vl);
        int t;
        t = (int'(vl) - 1) / lanes_p;
        if (t < 0) begin
            t = 0;
        end else begin
            t = t;
        end
        return t[bw-1:0];
    endfunction

    state_e                state_r;
    state_e                state_next_s;
    logic [bw-1:0]         beat_r;
    logic [bw-1:0]         beat_next_s;
    logic [vaw-1:0]        vd_r;
    logic [vaw-1:0]        vs1_r;
    logic [vaw-1:0]        vs2_r;
    logic [vlw-1:0]        vl_r;
    logic [vlw-1:0]        vl_eff_s;
    logic                  accept_s;

    logic                  iss_v_s;
    logic [bw-1:0]         iss_beat_s;
    logic [vaw-1:0]        iss_vs1_s;
    logic [vaw-1:0]        iss_vs2_s;
    logic [vlw-1:0]        iss_vl_s;
    logic [lanes_p-1:0]    iss_mask_s;
    logic                  iss_last_s;
    logic [lanes_p*aw-1:0] iss_r0_s;
    logic [lanes_p*aw-1:0] iss_r1_s;

    wbeat_t                pipe_r [exe_latency_p];
    wbeat_t                wb_s;
    logic [lanes_p*aw-1:0] wb_addr_s;
    logic                  done_next_s;

    logic                  ready_r;
    logic [lanes_p-1:0]    exe_v_r;
    logic [lanes_p*aw-1:0] r0_addr_r;
    logic [lanes_p*aw-1:0] r1_addr_r;
    logic [lanes_p*aw-1:0] w_addr_r;
    logic [lanes_p-1:0]    w_en_r;
    logic                  done_r;

    assign ready_o   = ready_r;
    assign exe_v_o   = exe_v_r;
    assign r0_addr_o = r0_addr_r;
    assign r1_addr_o = r1_addr_r;
    assign w_addr_o  = w_addr_r;
    assign w_en_o    = w_en_r;
    assign done_o    = done_r;

    // Clamp the requested length to the vector size.
    always_comb begin
        vl_eff_s = vl_i;
        if (vl_i > vlw'(vlen_p)) begin
            vl_eff_s = vlw'(vlen_p);
        end else begin
            vl_eff_s = vl_i;
        end
    end

    // Next-state logic; also selects which beat (if any) is issued next cycle.
    always_comb begin
        state_next_s = state_r;
        beat_next_s  = beat_r;
        accept_s     = 1'b0;
        iss_v_s      = 1'b0;
        iss_beat_s   = beat_r;
        iss_vs1_s    = vs1_r;
        iss_vs2_s    = vs2_r;
        iss_vl_s     = vl_r;
        case (state_r)
            IDLE: begin
                if (v_i && ready_r) begin
                    accept_s = 1'b1;
                    if (vl_eff_s == {vlw{1'b0}}) begin
                        state_next_s = DRAIN;
                    end else begin
                        state_next_s = ISSUE;
                        beat_next_s  = {bw{1'b0}};
                        iss_v_s      = 1'b1;
                        iss_beat_s   = {bw{1'b0}};
                        iss_vs1_s    = vs1_i;
                        iss_vs2_s    = vs2_i;
                        iss_vl_s     = vl_eff_s;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (beat_r == last_beat(vl_r)) begin
                    state_next_s = DRAIN;
                end else begin
                    beat_next_s = beat_r + bw'(1);
                    iss_v_s     = 1'b1;
                    iss_beat_s  = beat_r + bw'(1);
                end
            end
            DRAIN: begin
                if (done_r) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Per-lane addresses for the beat being issued and the beat being written.
    always_comb begin
        iss_mask_s = lane_mask(iss_beat_s, iss_vl_s);
        iss_last_s = (iss_beat_s == last_beat(iss_vl_s));
        wb_s       = pipe_r[exe_latency_p-1];
        iss_r0_s   = {(lanes_p*aw){1'b0}};
        iss_r1_s   = {(lanes_p*aw){1'b0}};
        wb_addr_s  = {(lanes_p*aw){1'b0}};
        for (int l = 0; l < lanes_p; l++) begin
            iss_r0_s[l*aw +: aw]  = {iss_vs1_s, elem_idx(iss_beat_s, l)};
            iss_r1_s[l*aw +: aw]  = {iss_vs2_s, elem_idx(iss_beat_s, l)};
            wb_addr_s[l*aw +: aw] = {vd_r, elem_idx(wb_s.beat, l)};
        end
        done_next_s = (accept_s && (vl_eff_s == {vlw{1'b0}})) || (wb_s.v && wb_s.last);
    end

    // FSM state, beat counter and operand capture at handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            beat_r  <= {bw{1'b0}};
            vd_r    <= {vaw{1'b0}};
            vs1_r   <= {vaw{1'b0}};
            vs2_r   <= {vaw{1'b0}};
            vl_r    <= {vlw{1'b0}};
        end else begin
            state_r <= state_next_s;
            beat_r  <= beat_next_s;
            if (accept_s) begin
                vd_r  <= vd_i;
                vs1_r <= vs1_i;
                vs2_r <= vs2_i;
                vl_r  <= vl_eff_s;
            end
        end
    end

    // Registered read-side outputs; addresses hold between ops.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ready_r   <= 1'b1;
            exe_v_r   <= {lanes_p{1'b0}};
            r0_addr_r <= {(lanes_p*aw){1'b0}};
            r1_addr_r <= {(lanes_p*aw){1'b0}};
        end else begin
            ready_r <= (state_next_s == IDLE);
            exe_v_r <= iss_v_s ? iss_mask_s : {lanes_p{1'b0}};
            if (iss_v_s) begin
                r0_addr_r <= iss_r0_s;
                r1_addr_r <= iss_r1_s;
            end
        end
    end

    // Execution-latency shift register; stage 0 is aligned with the read beat.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < exe_latency_p; k++) begin
                pipe_r[k] <= '0;
            end
        end else begin
            pipe_r[0] <= {iss_v_s, iss_last_s, iss_mask_s, iss_beat_s};
            for (int k = 1; k < exe_latency_p; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
        end
    end

    // Registered write-side outputs and completion pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            w_addr_r <= {(lanes_p*aw){1'b0}};
            w_en_r   <= {lanes_p{1'b0}};
            done_r   <= 1'b0;
        end else begin
            w_en_r <= wb_s.v ? wb_s.mask : {lanes_p{1'b0}};
            done_r <= done_next_s;
            if (wb_s.v) begin
                w_addr_r <= wb_addr_s;
            end
        end
    end

`ifdef VRF_SEQ_PERF_EN
    logic [31:0] ops_done_r;

    // Completed-op counter, stepped together with each done pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ops_done_r <= 32'd0;
        end else if (done_next_s) begin
            ops_done_r <= ops_done_r + 32'd1;
        end else begin
            ops_done_r <= ops_done_r;
        end
    end

    assign ops_done_o = ops_done_r;
`endif

endmodule

// File: tb/tb_vrf_seq.sv
// Scoreboard bench for vrf_seq: stimulus queues expected beats, a negedge monitor checks them.
module tb_vrf_seq;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  m;
    } ev_t;

    logic        clk_i   = 1'b0;
    logic        reset_i = 1'b1;
    logic        v_i     = 1'b0;
    logic [4:0]  vd_i    = 5'd0;
    logic [4:0]  vs1_i   = 5'd0;
    logic [4:0]  vs2_i   = 5'd0;
    logic [3:0]  vl_i    = 4'd0;
    logic        ready_o;
    logic [31:0] r0_addr_o;
    logic [31:0] r1_addr_o;
    logic [3:0]  exe_v_o;
    logic [31:0] w_addr_o;
    logic [3:0]  w_en_o;
    logic        done_o;
`ifdef VRF_SEQ_PERF_EN
    logic [31:0] ops_done_o;
`endif

    int  checks  = 0;
    int  passes  = 0;
    int  cyc     = 0;
    int  exp_ops = 0;
    bit  mon_en  = 1'b0;
    ev_t rdq[$];
    ev_t wrq[$];
    int  doneq[$];
    ev_t mon_rd;
    ev_t mon_wr;
    int  mon_d;
    int  t1;
    int  t2;

    vrf_seq dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .vd_i      (vd_i),
        .vs1_i     (vs1_i),
        .vs2_i     (vs2_i),
        .vl_i      (vl_i),
        .r0_addr_o (r0_addr_o),
        .r1_addr_o (r1_addr_o),
        .exe_v_o   (exe_v_o),
        .w_addr_o  (w_addr_o),
        .w_en_o    (w_en_o),
        .done_o    (done_o)
`ifdef VRF_SEQ_PERF_EN
        ,
        .ops_done_o(ops_done_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Four lane addresses {reg, elem} for elements b*4 .. b*4+3.
    function automatic logic [31:0] pack(input logic [4:0] r, input int b);
        logic [31:0] p;
        int          v;
        p = 32'd0;
        for (int l = 0; l < 4; l++) begin
            v = int'(r) * 8 + b * 4 + l;
            p[l*8 +: 8] = v[7:0];
        end
        return p;
    endfunction

    function automatic logic [3:0] mask_of(input int b, input int vle);
        logic [3:0] m;
        m = 4'd0;
        for (int l = 0; l < 4; l++) begin
            m[l] = ((b * 4 + l) < vle);
        end
        return m;
    endfunction

    task automatic push_exp(input int t, input logic [4:0] vd, input logic [4:0] vs1,
                            input logic [4:0] vs2, input int vl, input bit writes);
        int  vle;
        int  nb;
        ev_t e;
        vle = (vl > 8) ? 8 : vl;
        if (vle == 0) begin
            if (writes) begin
                doneq.push_back(t + 1);
                exp_ops++;
            end
        end else begin
            nb = (vle + 3) / 4;
            for (int b = 0; b < nb; b++) begin
                e.cyc = t + 1 + b;
                e.a   = pack(vs1, b);
                e.b   = pack(vs2, b);
                e.m   = mask_of(b, vle);
                rdq.push_back(e);
                if (writes) begin
                    e.cyc = t + 3 + b;
                    e.a   = pack(vd, b);
                    e.b   = 32'd0;
                    wrq.push_back(e);
                end
            end
            if (writes) begin
                doneq.push_back(t + 2 + nb);
                exp_ops++;
            end
        end
    endtask

    task automatic send(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                        input logic [3:0] vl, input bit hold, input bit writes, output int t);
        bit got;
        got   = 1'b0;
        t     = -1;
        vd_i  = vd;
        vs1_i = vs1;
        vs2_i = vs2;
        vl_i  = vl;
        v_i   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (!got) begin
                @(negedge clk_i);
                if (ready_o) begin
                    got = 1'b1;
                    t   = cyc;
                    push_exp(t, vd, vs1, vs2, int'(vl), writes);
                end
            end
        end
        if (!got) chk("handshake_timeout", 64'(0), 64'(1));
        @(posedge clk_i);
        #1;
        if (!hold) v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Monitor: pop and compare whenever the DUT presents a read beat, write beat or done.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (exe_v_o != 4'd0) begin
                if (rdq.size() == 0) begin
                    chk("rd_unexpected", 64'(exe_v_o), 64'(0));
                end else begin
                    mon_rd = rdq.pop_front();
                    chk("rd_cycle", 64'(cyc), 64'(mon_rd.cyc));
                    chk("rd_r0_addr", 64'(r0_addr_o), 64'(mon_rd.a));
                    chk("rd_r1_addr", 64'(r1_addr_o), 64'(mon_rd.b));
                    chk("rd_exe_v", 64'(exe_v_o), 64'(mon_rd.m));
                end
            end
            if (w_en_o != 4'd0) begin
                if (wrq.size() == 0) begin
                    chk("wr_unexpected", 64'(w_en_o), 64'(0));
                end else begin
                    mon_wr = wrq.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(mon_wr.cyc));
                    chk("wr_addr", 64'(w_addr_o), 64'(mon_wr.a));
                    chk("wr_en", 64'(w_en_o), 64'(mon_wr.m));
                end
            end
            if (done_o) begin
                if (doneq.size() == 0) begin
                    chk("done_unexpected", 64'(done_o), 64'(0));
                end else begin
                    mon_d = doneq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mon_d));
                end
            end
            if (rdq.size() > 0 && rdq[0].cyc < cyc) begin
                chk("rd_missing", 64'(cyc), 64'(rdq[0].cyc));
                void'(rdq.pop_front());
            end
            if (wrq.size() > 0 && wrq[0].cyc < cyc) begin
                chk("wr_missing", 64'(cyc), 64'(wrq[0].cyc));
                void'(wrq.pop_front());
            end
            if (doneq.size() > 0 && doneq[0] < cyc) begin
                chk("done_missing", 64'(cyc), 64'(doneq[0]));
                void'(doneq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", 64'(ready_o), 64'(1));
        chk("rst_exe_v", 64'(exe_v_o), 64'(0));
        chk("rst_w_en", 64'(w_en_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_r0_addr", 64'(r0_addr_o), 64'(0));
        chk("rst_r1_addr", 64'(r1_addr_o), 64'(0));
        chk("rst_w_addr", 64'(w_addr_o), 64'(0));
`ifdef VRF_SEQ_PERF_EN
        chk("rst_ops_done", 64'(ops_done_o), 64'(0));
`endif
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        mon_en  = 1'b1;
        idle(2);

        // Full-length op: vd=3, vs1=1, vs2=2, vl=8.
        send(5'd3, 5'd1, 5'd2, 4'd8, 1'b0, 1'b1, t1);
        idle(8);
        // Partial last beat: vl=5 leaves only element 4 in beat 1.
        send(5'd7, 5'd4, 5'd5, 4'd5, 1'b0, 1'b1, t1);
        idle(8);
        // vl=0 then a held single-beat op with vd equal to both sources.
        send(5'd9, 5'd6, 5'd6, 4'd0, 1'b1, 1'b1, t1);
        send(5'd1, 5'd1, 5'd1, 4'd4, 1'b0, 1'b1, t2);
        chk("spacing_vl0", 64'(t2 - t1), 64'(2));
        idle(8);
        // vl=9 clamps to 8.
        send(5'd3, 5'd1, 5'd2, 4'd9, 1'b0, 1'b1, t1);
        idle(8);
        // Back-to-back full ops with v_i held high.
        send(5'd10, 5'd11, 5'd12, 4'd8, 1'b1, 1'b1, t1);
        send(5'd13, 5'd14, 5'd15, 4'd8, 1'b0, 1'b1, t2);
        chk("spacing_b2b", 64'(t2 - t1), 64'(5));
        idle(10);
`ifdef VRF_SEQ_PERF_EN
        chk("ops_done_count", 64'(ops_done_o), 64'(exp_ops));
`endif

        // Reset during cycle T+2 of a full op: reads seen, no writes, no done.
        send(5'd3, 5'd1, 5'd2, 4'd8, 1'b0, 1'b0, t1);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
`ifdef VRF_SEQ_PERF_EN
        chk("ops_done_before_reset", 64'(ops_done_o), 64'(exp_ops));
`endif
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        exp_ops = 0;
        @(negedge clk_i);
        chk("abort_cycle", 64'(cyc), 64'(t1 + 3));
        chk("abort_ready", 64'(ready_o), 64'(1));
        chk("abort_w_en", 64'(w_en_o), 64'(0));
        chk("abort_done", 64'(done_o), 64'(0));
`ifdef VRF_SEQ_PERF_EN
        chk("ops_done_after_reset", 64'(ops_done_o), 64'(0));
`endif
        idle(10);

        chk("rd_queue_drained", 64'(rdq.size()), 64'(0));
        chk("wr_queue_drained", 64'(wrq.size()), 64'(0));
        chk("done_queue_drained", 64'(doneq.size()), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
